// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac -- one fixed-point neuron: dot product of a streamed input vector
// with a weight vector read from an external registered memory, plus bias,
// rescaled, saturated and (optionally) ReLU-activated.
//
// Configuration macro: NEURON_RELU_EN
//   defined   -> negative saturated results are output as 0 (ReLU)
//   undefined -> saturated result is output unchanged (linear)
//
// Ports
//   clk       : single clock, all logic on the rising edge
//   rst       : synchronous, active-high reset
//   in_data   : signed input activation
//   in_valid  : in_data valid this cycle
//   in_ready  : block accepts a beat this cycle (beat = in_valid & in_ready)
//   bias      : signed neuron bias, stable for the whole vector
//   w_ren     : weight-memory read enable (combinational, = accepted beat)
//   w_radd    : weight-memory read address (= beat counter)
//   w_data    : signed weight, returned one cycle after w_ren
//   out_data  : signed registered neuron output, held until the next result
//   out_valid : one-cycle pulse marking a new out_data
// -----------------------------------------------------------------------------
module neuron_mac #(
   parameter int numWeight    = 30,
   parameter int dataWidth    = 16,
   parameter int fracWidth    = 12,
   parameter int addressWidth = $clog2(numWeight)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [dataWidth-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [dataWidth-1:0] bias,
   output logic                        w_ren,
   output logic [addressWidth-1:0]     w_radd,
   input  logic signed [dataWidth-1:0] w_data,
   output logic signed [dataWidth-1:0] out_data,
   output logic                        out_valid
);

   // Accumulator is wide enough for numWeight full-precision products.
   localparam int ACC_W = 2*dataWidth + addressWidth;
   // One extra bit so adding the scaled bias can never wrap.
   localparam int SUM_W = ACC_W + 1;

   localparam logic [addressWidth-1:0]     LAST    = addressWidth'(numWeight - 1);
   localparam logic signed [dataWidth-1:0] OUT_MAX = {1'b0, {(dataWidth-1){1'b1}}};
   localparam logic signed [dataWidth-1:0] OUT_MIN = {1'b1, {(dataWidth-1){1'b0}}};
   localparam logic signed [SUM_W-1:0]     SAT_MAX = SUM_W'(OUT_MAX);
   localparam logic signed [SUM_W-1:0]     SAT_MIN = SUM_W'(OUT_MIN);

   typedef enum logic [1:0] {ACC, DRAIN, FIN} state_t;

   state_t                        state;
   logic [addressWidth-1:0]       cnt;
   logic signed [ACC_W-1:0]       acc;
   logic signed [dataWidth-1:0]   d_data;   // in_data delayed to meet w_data
   logic                          d_valid;
   logic signed [2*dataWidth-1:0] prod;
   logic signed [SUM_W-1:0]       sum;
   logic signed [SUM_W-1:0]       res;
   logic signed [dataWidth-1:0]   sat;
   logic signed [dataWidth-1:0]   act;

   assign in_ready = (state == ACC) && !rst;
   assign w_ren    = in_valid && in_ready;
   assign w_radd   = cnt;

   // Both operands sign-extended first so the low 2*dataWidth bits are exact.
   assign prod = (2*dataWidth)'(d_data) * (2*dataWidth)'(w_data);

   always_comb begin
      // NOTE: every combinational output gets a value on every path (here via
      // a default before the branches) so no latch is inferred.
      sum = SUM_W'(acc) + (SUM_W'(bias) <<< fracWidth);
      res = sum >>> fracWidth;   // arithmetic shift: truncates toward -inf
      sat = res[dataWidth-1:0];
      if (res > SAT_MAX) begin
         sat = OUT_MAX;
      end else if (res < SAT_MIN) begin
         sat = OUT_MIN;
      end
      act = sat;
`ifdef NEURON_RELU_EN
      if (sat < 0) begin
         act = '0;
      end
`else
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= '0;
         d_data    <= '0;
         d_valid   <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         d_valid   <= w_ren;
         d_data    <= in_data;
         if (d_valid) begin
            acc <= acc + ACC_W'(prod);
         end

         case (state)
            ACC: begin
               if (w_ren) begin
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= DRAIN;
                  end else begin
                     cnt <= cnt + addressWidth'(1);
                  end
               end
            end
            // Last product lands in acc during this cycle.
            DRAIN: state <= FIN;
            FIN: begin
               out_data  <= act;
               out_valid <= 1'b1;
               acc       <= '0;   // no beat can be in flight here
               state     <= ACC;
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac -- self-checking bench for neuron_mac (default parameters).
// Expected results come from an integer dot-product model (floor division by
// 2^12, clamp to 16-bit, optional ReLU) or from hand-derived constants.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

   localparam int N = 30;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] bias;
   logic               w_ren;
   logic [4:0]         w_radd;
   logic signed [15:0] w_data;
   logic signed [15:0] out_data;
   logic               out_valid;

   int total = 0;
   int bad   = 0;

   int                 xs    [N];
   logic signed [15:0] w_mem [N];

   neuron_mac dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bias      (bias),
      .w_ren     (w_ren),
      .w_radd    (w_radd),
      .w_data    (w_data),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Registered-read weight memory.
   always @(posedge clk) begin
      if (w_ren) w_data <= w_mem[w_radd];
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model(input int b);
      longint s = 0;
      longint r;
      for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(w_mem[i]);
      s += longint'(b) * 4096;
      r = s >>> 12;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`ifdef NEURON_RELU_EN
      if (r < 0) r = 0;
`else
`endif
      return r[15:0];
   endfunction

   // mode: 0 = back-to-back, 1 = alternating valid, 2 = random gaps
   task automatic run_vector(input string tag, input int b, input int mode,
                             input logic [15:0] exp);
      int  i   = 0;
      bit  alt = 1'b1;
      bias = 16'(b);
      while (i < N) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = alt;
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         alt     = ~alt;
         in_data = 16'(xs[i]);
         #1;
         check({tag, " w_radd"}, 16'(w_radd), 16'(i));
         check({tag, " w_ren"}, 16'(w_ren), 16'(in_valid));
         if (in_valid) i++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check({tag, " drain out_valid"}, 16'(out_valid), 16'd0);
      check({tag, " drain in_ready"}, 16'(in_ready), 16'd0);
      tick();
      check({tag, " fin out_valid"}, 16'(out_valid), 16'd0);
      tick();
      check({tag, " out_valid"}, 16'(out_valid), 16'd1);
      check({tag, " out_data"}, out_data, exp);
      check({tag, " ready again"}, 16'(in_ready), 16'd1);
      check({tag, " w_radd wrap"}, 16'(w_radd), 16'd0);
      tick();
      check({tag, " pulse end"}, 16'(out_valid), 16'd0);
      check({tag, " out_data hold"}, out_data, exp);
   endtask

   task automatic fill(input int x, input int w);
      for (int i = 0; i < N; i++) begin
         xs[i]    = x;
         w_mem[i] = 16'(w);
      end
   endtask

   initial begin
      logic [15:0] exp_neg;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      bias     = '0;

      // Reset behaviour
      tick();
      tick();
      check("rst in_ready", 16'(in_ready), 16'd0);
      check("rst out_valid", 16'(out_valid), 16'd0);
      check("rst out_data", out_data, 16'h0000);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", 16'(in_ready), 16'd1);
      check("post-rst w_radd", 16'(w_radd), 16'd0);
      tick();

      // 0.25 * 0.5 * 30 = 3.75
      fill(32'h0400, 32'h0800);
      run_vector("basic", 0, 0, 16'h3C00);

      // Negative bias: -0.25 linear, clamped to 0 with ReLU
`ifdef NEURON_RELU_EN
      exp_neg = 16'h0000;
`else
      exp_neg = 16'hFC00;
`endif
      run_vector("neg bias", -16384, 0, exp_neg);

      // Positive saturation
      fill(32'h7FFF, 32'h7FFF);
      run_vector("sat", 32'h7FFF, 0, 16'h7FFF);

      // Alternating valid
      fill(32'h0400, 32'h0800);
      run_vector("gaps", 0, 1, 16'h3C00);

      // Abort after 10 beats, reset held with in_valid high
      bias     = '0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'(xs[i]);
         tick();
      end
      rst = 1'b1;
      #1;
      check("abort in_ready", 16'(in_ready), 16'd0);
      check("abort w_ren", 16'(w_ren), 16'd0);
      tick();
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("abort no pulse", 16'(out_valid), 16'd0);
         tick();
      end
      check("abort w_radd", 16'(w_radd), 16'd0);
      run_vector("after abort", 0, 0, 16'h3C00);

      // Randomised vectors against the model
      for (int v = 0; v < 6; v++) begin
         int b;
         for (int i = 0; i < N; i++) begin
            if (v < 3) begin
               xs[i]    = int'($urandom_range(0, 4095)) - 2048;
               w_mem[i] = 16'(int'($urandom_range(0, 8191)) - 4096);
            end else begin
               xs[i]    = int'($signed(16'($urandom)));
               w_mem[i] = 16'($urandom);
            end
         end
         b = int'($signed(16'($urandom)));
         run_vector($sformatf("rand%0d", v), b, 2, model(b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
